// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the crossbar read path: response codes and router states.
// DRAIN is only part of the state set when AXI_LITE_RD_TIMEOUT_EN is defined.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FWD_AR = 3'd1,
      WAIT_R = 3'd2,
`ifdef AXI_LITE_RD_TIMEOUT_EN
      ERR_R  = 3'd3,
      DRAIN  = 3'd4
`else
      ERR_R  = 3'd3
`endif
   } rd_router_state_e;

endpackage

// File: rtl/axi_lite_read_router.sv
// Single-outstanding AXI4-Lite read router: one master, NUM_SLAVE slaves, DECERR for unmapped reads.
// Define AXI_LITE_RD_TIMEOUT_EN to add the WAIT_R timeout (SLVERR) and the DRAIN state for late beats.
module axi_lite_read_router
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_SLAVE      = 4,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int IDX_W          = (NUM_SLAVE > 1) ? $clog2(NUM_SLAVE) : 1
)(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [ADDR_WIDTH-1:0]           ar_addr_i,
   input  logic [2:0]                      ar_prot_i,
   input  logic                            ar_valid_i,
   output logic                            ar_ready_o,
   output logic [DATA_WIDTH-1:0]           r_data_o,
   output logic [1:0]                      r_resp_o,
   output logic                            r_valid_o,
   input  logic                            r_ready_i,
   output logic [ADDR_WIDTH-1:0]           res_addr_o,
   input  logic [IDX_W-1:0]                res_idx_i,
   input  logic                            res_ok_i,
   output logic [ADDR_WIDTH-1:0]           sl_ar_addr_o,
   output logic [2:0]                      sl_ar_prot_o,
   output logic [NUM_SLAVE-1:0]            sl_ar_valid_o,
   input  logic [NUM_SLAVE-1:0]            sl_ar_ready_i,
   input  logic [NUM_SLAVE*DATA_WIDTH-1:0] sl_r_data_i,
   input  logic [NUM_SLAVE*2-1:0]          sl_r_resp_i,
   input  logic [NUM_SLAVE-1:0]            sl_r_valid_i,
   output logic [NUM_SLAVE-1:0]            sl_r_ready_o
);

   localparam logic [IDX_W:0] NUM_SLAVE_W = (IDX_W+1)'(NUM_SLAVE);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   rd_router_state_e        state_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [2:0]              prot_q;
   logic [IDX_W-1:0]        idx_q;
   logic [1:0]              resp_q;

`ifdef AXI_LITE_RD_TIMEOUT_EN
   localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0]             cnt_q;
   logic                         timed_out_q;
   logic                         drained_q;
`endif

   logic [NUM_SLAVE-1:0]    sel_oh;
   logic                    sel_ar_ready;
   logic                    sel_r_valid;
   logic [DATA_WIDTH-1:0]   sel_r_data;
   logic [1:0]              sel_r_resp;
   logic                    map_ok;

   // An index beyond the slave count is treated exactly like a resolver miss.
   assign map_ok = res_ok_i && ({1'b0, res_idx_i} < NUM_SLAVE_W);

   always_comb begin
      sel_oh       = '0;
      sel_r_data   = '0;
      sel_r_resp   = 2'b00;
      for (int i = 0; i < NUM_SLAVE; i++) begin
         sel_oh[i]  = (idx_q == IDX_W'(i));
         sel_r_data = sel_r_data | (sl_r_data_i[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_oh[i]}});
         sel_r_resp = sel_r_resp | (sl_r_resp_i[i*2 +: 2] & {2{sel_oh[i]}});
      end
      sel_ar_ready = |(sl_ar_ready_i & sel_oh);
      sel_r_valid  = |(sl_r_valid_i & sel_oh);
   end

   // Outputs are gated by rst_i so that an asserted reset silences every handshake at once.
   always_comb begin
      ar_ready_o    = 1'b0;
      r_valid_o     = 1'b0;
      r_data_o      = '0;
      r_resp_o      = 2'b00;
      res_addr_o    = addr_q;
      sl_ar_addr_o  = addr_q;
      sl_ar_prot_o  = prot_q;
      sl_ar_valid_o = '0;
      sl_r_ready_o  = '0;
      if (rst_i) begin
         ar_ready_o = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               ar_ready_o = 1'b1;
               res_addr_o = ar_addr_i;
            end
            FWD_AR: begin
               sl_ar_valid_o = sel_oh;
            end
            WAIT_R: begin
               r_valid_o    = sel_r_valid;
               r_data_o     = sel_r_data;
               r_resp_o     = sel_r_resp;
               sl_r_ready_o = sel_oh & {NUM_SLAVE{r_ready_i}};
            end
            ERR_R: begin
               r_valid_o = 1'b1;
               r_resp_o  = resp_q;
`ifdef AXI_LITE_RD_TIMEOUT_EN
               sl_r_ready_o = sel_oh & {NUM_SLAVE{timed_out_q}};
`endif
            end
`ifdef AXI_LITE_RD_TIMEOUT_EN
            DRAIN: begin
               sl_r_ready_o = sel_oh;
            end
`endif
            default: begin
               ar_ready_o = 1'b0;
            end
         endcase
      end
   end

   // Transaction FSM and request latches.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         prot_q      <= 3'b000;
         idx_q       <= '0;
         resp_q      <= 2'b00;
`ifdef AXI_LITE_RD_TIMEOUT_EN
         cnt_q       <= '0;
         timed_out_q <= 1'b0;
         drained_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (ar_valid_i) begin
                  addr_q <= ar_addr_i;
                  prot_q <= ar_prot_i;
                  idx_q  <= res_idx_i;
                  resp_q <= RESP_DECERR;
`ifdef AXI_LITE_RD_TIMEOUT_EN
                  timed_out_q <= 1'b0;
                  drained_q   <= 1'b0;
`endif
                  state_q <= map_ok ? FWD_AR : ERR_R;
               end
            end
            FWD_AR: begin
               if (sel_ar_ready) begin
                  state_q <= WAIT_R;
`ifdef AXI_LITE_RD_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            WAIT_R: begin
               // A beat in the final counted cycle still completes normally.
               if (sel_r_valid && r_ready_i) begin
                  state_q <= IDLE;
`ifdef AXI_LITE_RD_TIMEOUT_EN
               end else if (cnt_q == CNT_MAX) begin
                  state_q     <= ERR_R;
                  resp_q      <= RESP_SLVERR;
                  timed_out_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
`endif
               end
            end
            ERR_R: begin
`ifdef AXI_LITE_RD_TIMEOUT_EN
               if (timed_out_q && sel_r_valid) begin
                  drained_q <= 1'b1;
               end
               if (r_ready_i) begin
                  state_q <= (timed_out_q && !drained_q && !sel_r_valid) ? DRAIN : IDLE;
               end
`else
               if (r_ready_i) begin
                  state_q <= IDLE;
               end
`endif
            end
`ifdef AXI_LITE_RD_TIMEOUT_EN
            DRAIN: begin
               if (sel_r_valid) begin
                  state_q <= IDLE;
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_lite_read_router.sv
// Directed bench for axi_lite_read_router: vector table of single reads plus backpressure,
// reset and (with AXI_LITE_RD_TIMEOUT_EN) timeout sequences.
module tb_axi_lite_read_router;
   import axi_lite_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int IW = 2;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [AW-1:0]      ar_addr_i;
   logic [2:0]         ar_prot_i;
   logic               ar_valid_i;
   logic               ar_ready_o;
   logic [DW-1:0]      r_data_o;
   logic [1:0]         r_resp_o;
   logic               r_valid_o;
   logic               r_ready_i;
   logic [AW-1:0]      res_addr_o;
   logic [IW-1:0]      res_idx_i;
   logic               res_ok_i;
   logic [AW-1:0]      sl_ar_addr_o;
   logic [2:0]         sl_ar_prot_o;
   logic [NS-1:0]      sl_ar_valid_o;
   logic [NS-1:0]      sl_ar_ready_i;
   logic [NS*DW-1:0]   sl_r_data_i;
   logic [NS*2-1:0]    sl_r_resp_i;
   logic [NS-1:0]      sl_r_valid_i;
   logic [NS-1:0]      sl_r_ready_o;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  prot;
      logic        mapped;
      logic [3:0]  oh;
      logic [31:0] data;
      logic [1:0]  sresp;
      logic [1:0]  exp_resp;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [5];

   axi_lite_read_router #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVE(NS), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ar_addr_i(ar_addr_i), .ar_prot_i(ar_prot_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .res_addr_o(res_addr_o), .res_idx_i(res_idx_i), .res_ok_i(res_ok_i),
      .sl_ar_addr_o(sl_ar_addr_o), .sl_ar_prot_o(sl_ar_prot_o),
      .sl_ar_valid_o(sl_ar_valid_o), .sl_ar_ready_i(sl_ar_ready_i),
      .sl_r_data_i(sl_r_data_i), .sl_r_resp_i(sl_r_resp_i),
      .sl_r_valid_i(sl_r_valid_i), .sl_r_ready_o(sl_r_ready_o)
   );

   always #5 clk_i = ~clk_i;

   // Resolver model: fixed address map, everything else unmapped.
   always_comb begin
      res_ok_i  = 1'b0;
      res_idx_i = 2'd0;
      case (res_addr_o)
         32'h0000_0000: begin res_ok_i = 1'b1; res_idx_i = 2'd0; end
         32'h0000_1000: begin res_ok_i = 1'b1; res_idx_i = 2'd2; end
         32'h0000_2000: begin res_ok_i = 1'b1; res_idx_i = 2'd1; end
         32'h0000_3000: begin res_ok_i = 1'b1; res_idx_i = 2'd3; end
         default:       begin res_ok_i = 1'b0; res_idx_i = 2'd0; end
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load_slaves(input logic [3:0] oh, input logic [31:0] data, input logic [1:0] resp);
      for (int i = 0; i < NS; i++) begin
         sl_r_data_i[i*DW +: DW] = oh[i] ? data : ~data;
         sl_r_resp_i[i*2 +: 2]   = oh[i] ? resp : ~resp;
      end
   endtask

   task automatic run_vec(input vec_t v);
      ar_addr_i  = v.addr;
      ar_prot_i  = v.prot;
      ar_valid_i = 1'b1;
      #1;
      chk("idle_ar_ready", ar_ready_o, 1);
      chk("idle_res_addr", res_addr_o, v.addr);
      step();
      ar_valid_i = 1'b0;
      ar_addr_i  = 32'hFFFF_FFFF;
      ar_prot_i  = 3'b000;
      #1;
      if (v.mapped) begin
         chk("fwd_sl_ar_valid", sl_ar_valid_o, v.oh);
         chk("fwd_sl_ar_addr", sl_ar_addr_o, v.addr);
         chk("fwd_sl_ar_prot", sl_ar_prot_o, v.prot);
         chk("fwd_ar_ready", ar_ready_o, 0);
         chk("fwd_r_valid", r_valid_o, 0);
         sl_ar_ready_i = v.oh;
         step();
         sl_ar_ready_i = 4'b0000;
         load_slaves(v.oh, v.data, v.sresp);
         sl_r_valid_i = 4'b1111;
         r_ready_i    = 1'b1;
         #1;
         chk("wait_r_valid", r_valid_o, 1);
         chk("wait_r_data", r_data_o, v.exp_data);
         chk("wait_r_resp", r_resp_o, v.exp_resp);
         chk("wait_sl_r_ready", sl_r_ready_o, v.oh);
         chk("wait_sl_ar_valid", sl_ar_valid_o, 0);
      end else begin
         chk("err_r_valid", r_valid_o, 1);
         chk("err_r_resp", r_resp_o, v.exp_resp);
         chk("err_r_data", r_data_o, v.exp_data);
         chk("err_sl_ar_valid", sl_ar_valid_o, 0);
         sl_r_valid_i = 4'b1111;
         r_ready_i    = 1'b1;
         #1;
         chk("err_sl_r_ready", sl_r_ready_o, 0);
      end
      step();
      sl_r_valid_i = 4'b0000;
      r_ready_i    = 1'b0;
      #1;
      chk("done_ar_ready", ar_ready_o, 1);
      chk("done_r_valid", r_valid_o, 0);
   endtask

   task automatic start_mapped(input logic [31:0] addr, input logic [3:0] oh);
      ar_addr_i  = addr;
      ar_prot_i  = 3'b000;
      ar_valid_i = 1'b1;
      step();
      ar_valid_i    = 1'b0;
      sl_ar_ready_i = oh;
      step();
      sl_ar_ready_i = 4'b0000;
   endtask

   initial begin
      tbl[0] = '{addr: 32'h0000_1000, prot: 3'b001, mapped: 1'b1, oh: 4'b0100, data: 32'hDEAD_BEEF,
                 sresp: 2'b00, exp_resp: 2'b00, exp_data: 32'hDEAD_BEEF};
      tbl[1] = '{addr: 32'h0000_9000, prot: 3'b000, mapped: 1'b0, oh: 4'b0000, data: 32'h0000_0000,
                 sresp: 2'b00, exp_resp: 2'b11, exp_data: 32'h0000_0000};
      tbl[2] = '{addr: 32'h0000_0000, prot: 3'b010, mapped: 1'b1, oh: 4'b0001, data: 32'h1234_5678,
                 sresp: 2'b00, exp_resp: 2'b00, exp_data: 32'h1234_5678};
      tbl[3] = '{addr: 32'h0000_3000, prot: 3'b111, mapped: 1'b1, oh: 4'b1000, data: 32'hCAFE_F00D,
                 sresp: 2'b10, exp_resp: 2'b10, exp_data: 32'hCAFE_F00D};
      tbl[4] = '{addr: 32'h0000_2000, prot: 3'b100, mapped: 1'b1, oh: 4'b0010, data: 32'h0BAD_F00D,
                 sresp: 2'b01, exp_resp: 2'b01, exp_data: 32'h0BAD_F00D};

      rst_i         = 1'b1;
      ar_addr_i     = 32'h0000_0000;
      ar_prot_i     = 3'b000;
      ar_valid_i    = 1'b0;
      r_ready_i     = 1'b0;
      sl_ar_ready_i = 4'b0000;
      sl_r_data_i   = '0;
      sl_r_resp_i   = '0;
      sl_r_valid_i  = 4'b0000;
      step();
      step();
      chk("rst_ar_ready", ar_ready_o, 0);
      chk("rst_r_valid", r_valid_o, 0);
      chk("rst_sl_ar_valid", sl_ar_valid_o, 0);
      chk("rst_sl_r_ready", sl_r_ready_o, 0);
      chk("rst_r_data", r_data_o, 0);
      chk("rst_r_resp", r_resp_o, 0);
      rst_i = 1'b0;
      #1;
      chk("post_rst_ar_ready", ar_ready_o, 1);

      // Rows run back to back: each AR is offered the cycle after the previous R handshake.
      for (int i = 0; i < 5; i++) begin
         run_vec(tbl[i]);
      end

      // Backpressure on slave 1 AR, then on master R.
      ar_addr_i  = 32'h0000_2000;
      ar_prot_i  = 3'b011;
      ar_valid_i = 1'b1;
      step();
      ar_valid_i = 1'b0;
      ar_addr_i  = 32'h0000_0000;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("bp_ar_valid", sl_ar_valid_o, 4'b0010);
         chk("bp_ar_addr", sl_ar_addr_o, 32'h0000_2000);
         chk("bp_ar_prot", sl_ar_prot_o, 3'b011);
         step();
      end
      sl_ar_ready_i = 4'b0010;
      step();
      sl_ar_ready_i = 4'b0000;
      load_slaves(4'b0010, 32'h55AA_33CC, 2'b00);
      sl_r_valid_i = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_r_valid", r_valid_o, 1);
         chk("bp_r_data", r_data_o, 32'h55AA_33CC);
         chk("bp_sl_r_ready", sl_r_ready_o, 0);
         step();
      end
      r_ready_i = 1'b1;
      #1;
      chk("bp_sl_r_ready_go", sl_r_ready_o, 4'b0010);
      step();
      r_ready_i    = 1'b0;
      sl_r_valid_i = 4'b0000;
      #1;
      chk("bp_done", ar_ready_o, 1);

      // Reset in the middle of WAIT_R.
      start_mapped(32'h0000_1000, 4'b0100);
      load_slaves(4'b0100, 32'hA5A5_5A5A, 2'b00);
      sl_r_valid_i = 4'b1111;
      r_ready_i    = 1'b1;
      #1;
      chk("mid_wait_sl_r_ready", sl_r_ready_o, 4'b0100);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_ar_ready", ar_ready_o, 0);
      chk("arst_r_valid", r_valid_o, 0);
      chk("arst_sl_r_ready", sl_r_ready_o, 0);
      chk("arst_sl_ar_valid", sl_ar_valid_o, 0);
      step();
      rst_i        = 1'b0;
      sl_r_valid_i = 4'b0000;
      r_ready_i    = 1'b0;
      #1;
      chk("arst_release_ar_ready", ar_ready_o, 1);
      chk("arst_release_r_valid", r_valid_o, 0);
      run_vec(tbl[2]);

`ifdef AXI_LITE_RD_TIMEOUT_EN
      // Silent slave: SLVERR after 8 WAIT_R cycles, late beat sunk in DRAIN.
      start_mapped(32'h0000_1000, 4'b0100);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("to_waiting", r_valid_o, 0);
         step();
      end
      #1;
      chk("to_r_valid", r_valid_o, 1);
      chk("to_r_resp", r_resp_o, 2'b10);
      chk("to_r_data", r_data_o, 0);
      chk("to_sink_ready", sl_r_ready_o, 4'b0100);
      r_ready_i = 1'b1;
      step();
      r_ready_i = 1'b0;
      #1;
      chk("drain_ar_ready", ar_ready_o, 0);
      chk("drain_r_valid", r_valid_o, 0);
      chk("drain_sl_r_ready", sl_r_ready_o, 4'b0100);
      step();
      load_slaves(4'b0100, 32'h1A7E_BEA7, 2'b00);
      sl_r_valid_i = 4'b0100;
      #1;
      chk("drain_late_r_valid", r_valid_o, 0);
      step();
      sl_r_valid_i = 4'b0000;
      #1;
      chk("drain_done_ar_ready", ar_ready_o, 1);
      chk("drain_done_r_valid", r_valid_o, 0);
      run_vec(tbl[0]);

      // Beat in the final counted cycle completes with OKAY.
      start_mapped(32'h0000_1000, 4'b0100);
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("edge_waiting", r_valid_o, 0);
         step();
      end
      load_slaves(4'b0100, 32'h600D_BEEF, 2'b00);
      sl_r_valid_i = 4'b0100;
      r_ready_i    = 1'b1;
      #1;
      chk("edge_r_valid", r_valid_o, 1);
      chk("edge_r_resp", r_resp_o, 2'b00);
      chk("edge_r_data", r_data_o, 32'h600D_BEEF);
      step();
      sl_r_valid_i = 4'b0000;
      r_ready_i    = 1'b0;
      #1;
      chk("edge_no_slverr", r_valid_o, 0);
      chk("edge_idle", ar_ready_o, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
